// File: rtl/fetch_pkg.sv
// Shared types and helpers for the prefetching IF stage.
package fetch_pkg;

    localparam int XLEN = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    // Ceil-log2 with a floor of 1 so single-entry counters still get a bit.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Show-ahead synchronous FIFO with push/pop/flush; the head entry is visible
// combinationally whenever the FIFO is non-empty.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DW    = 64,
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_push,
    input  logic [DW-1:0]               i_data,
    input  logic                        i_pop,
    input  logic                        i_flush,
    output logic [DW-1:0]               o_head,
    output logic [clog2(DEPTH+1)-1:0]   o_count,
    output logic                        o_full,
    output logic                        o_empty
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = clog2(DEPTH + 1);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Flush wins over any simultaneous push or pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

endmodule

// File: rtl/fetch_queue_stage.sv
// Prefetching IF stage: credit-limited imem requests, in-order responses into a
// FIFO, redirect flush with stale-response drop. Optional FETCH_PERF_CNT_EN.
module fetch_queue_stage
    import fetch_pkg::*;
#(
    parameter int              XLEN     = fetch_pkg::XLEN,
    parameter int              FQ_DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            imem_req_valid_o,
    input  logic            imem_req_ready_i,
    output logic [XLEN-1:0] imem_req_addr_o,
    input  logic            imem_rsp_valid_i,
    input  logic [XLEN-1:0] imem_rsp_data_i,
    output logic            instr_valid_o,
    input  logic            instr_ready_i,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus4_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     perf_stall_cycles_o,
    output logic [31:0]     perf_redirects_o
`endif
);

    localparam int            CW      = clog2(FQ_DEPTH + 1);
    localparam logic [CW:0]   DEPTH_W = (CW+1)'(FQ_DEPTH);
    localparam logic [XLEN-1:0] STEP  = XLEN'(4);

    logic [XLEN-1:0]   r_fetch_pc;
    logic [XLEN-1:0]   r_rsp_pc;
    logic [CW-1:0]     r_outstanding;
    logic [CW-1:0]     r_drop_cnt;
    logic [CW-1:0]     w_count;
    logic              w_full;
    logic              w_empty;
    logic              w_fire;
    logic              w_push;
    logic              w_pop;
    logic [XLEN-1:0]   w_target;
    logic [2*XLEN-1:0] w_head;

    // Credits cover both buffered and in-flight entries, so a response always has room.
    assign imem_req_valid_o = rst_n && !redirect_i &&
                              (({1'b0, w_count} + {1'b0, r_outstanding}) < DEPTH_W);
    assign imem_req_addr_o  = r_fetch_pc;
    assign w_fire   = imem_req_valid_o && imem_req_ready_i;
    assign w_push   = imem_rsp_valid_i && !redirect_i && (r_drop_cnt == '0);
    assign w_pop    = instr_valid_o && instr_ready_i;
    assign w_target = redirect_pc_i & ~XLEN'(3);

    assign instr_valid_o  = !w_empty;
    assign {pc_o, instr_o} = w_head;
    assign pc_plus4_o     = pc_o + STEP;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc    <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else begin
            r_outstanding <= r_outstanding + CW'(w_fire) - CW'(imem_rsp_valid_i);
            if (redirect_i) begin
                r_fetch_pc <= w_target;
                r_rsp_pc   <= w_target;
                // A response landing this cycle is already gone, so it is not counted.
                r_drop_cnt <= r_outstanding - CW'(imem_rsp_valid_i);
            end else begin
                if (w_fire) r_fetch_pc <= r_fetch_pc + STEP;
                if (w_push) r_rsp_pc <= r_rsp_pc + STEP;
                if (imem_rsp_valid_i && r_drop_cnt != '0) r_drop_cnt <= r_drop_cnt - CW'(1);
            end
        end
    end

    fetch_fifo #(
        .DW    (2*XLEN),
        .DEPTH (FQ_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  ({r_rsp_pc, imem_rsp_data_i}),
        .i_pop   (w_pop),
        .i_flush (redirect_i),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(w_push && w_full));

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_redirects;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cycles <= '0;
            r_redirects    <= '0;
        end else begin
            if (!instr_valid_o && !redirect_i && r_stall_cycles != '1)
                r_stall_cycles <= r_stall_cycles + 32'd1;
            if (redirect_i && r_redirects != '1)
                r_redirects <= r_redirects + 32'd1;
        end
    end

    assign perf_stall_cycles_o = r_stall_cycles;
    assign perf_redirects_o    = r_redirects;
`endif

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Cycle-table bench for fetch_queue_stage plus reset, mid-run reset and PC-wrap sequences.
module tb_fetch_queue_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        req_valid;
    logic        req_ready = 1'b0;
    logic [31:0] req_addr;
    logic        rsp_valid = 1'b0;
    logic [31:0] rsp_data = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;

    logic        w_req_valid;
    logic        w_req_ready = 1'b0;
    logic [31:0] w_req_addr;
    logic        w_rsp_valid = 1'b0;
    logic [31:0] w_rsp_data = '0;
    logic        w_instr_valid;
    logic [31:0] w_instr;
    logic [31:0] w_pc;
    logic [31:0] w_pc_plus4;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fetch_queue_stage #(.XLEN(32), .FQ_DEPTH(4), .RESET_PC(32'h0)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .imem_req_valid_o(req_valid), .imem_req_ready_i(req_ready),
        .imem_req_addr_o(req_addr),
        .imem_rsp_valid_i(rsp_valid), .imem_rsp_data_i(rsp_data),
        .instr_valid_o(instr_valid), .instr_ready_i(instr_ready),
        .instr_o(instr), .pc_o(pc), .pc_plus4_o(pc_plus4)
    );

    fetch_queue_stage #(.XLEN(32), .FQ_DEPTH(4), .RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
        .clk(clk), .rst_n(rst_n),
        .redirect_i(1'b0), .redirect_pc_i(32'h0),
        .imem_req_valid_o(w_req_valid), .imem_req_ready_i(w_req_ready),
        .imem_req_addr_o(w_req_addr),
        .imem_rsp_valid_i(w_rsp_valid), .imem_rsp_data_i(w_rsp_data),
        .instr_valid_o(w_instr_valid), .instr_ready_i(1'b1),
        .instr_o(w_instr), .pc_o(w_pc), .pc_plus4_o(w_pc_plus4)
    );

    typedef struct {
        logic        redir;
        logic [31:0] rpc;
        logic        rdy;
        logic        rv;
        logic [31:0] rd;
        logic        ir;
        logic        ereq;
        logic [31:0] eaddr;
        logic        eiv;
        logic [31:0] epc;
        logic [31:0] einstr;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add(input logic redir, input logic [31:0] rpc, input logic rdy,
                       input logic rv, input logic [31:0] rd, input logic ir,
                       input logic ereq, input logic [31:0] eaddr,
                       input logic eiv, input logic [31:0] epc, input logic [31:0] einstr);
        vec_t v;
        v.redir = redir; v.rpc = rpc; v.rdy = rdy; v.rv = rv; v.rd = rd; v.ir = ir;
        v.ereq = ereq; v.eaddr = eaddr; v.eiv = eiv; v.epc = epc; v.einstr = einstr;
        vecs.push_back(v);
    endtask

    initial begin
        // redir rpc  rdy rv rd  ir | req addr  iv pc  instr
        // streaming, zero-wait memory
        add(0, 0, 1, 0, 32'h0,         1, 1, 32'h00, 0, 0, 0);
        add(0, 0, 1, 1, 32'hA000_0000, 1, 1, 32'h04, 0, 0, 0);
        add(0, 0, 1, 1, 32'hA000_0004, 1, 1, 32'h08, 1, 32'h00, 32'hA000_0000);
        add(0, 0, 1, 1, 32'hA000_0008, 1, 1, 32'h0C, 1, 32'h04, 32'hA000_0004);
        add(0, 0, 0, 1, 32'hA000_000C, 1, 1, 32'h10, 1, 32'h08, 32'hA000_0008);
        // decode stall: credits run out at four buffered+in-flight
        add(0, 0, 0, 0, 32'h0,         0, 1, 32'h10, 1, 32'h0C, 32'hA000_000C);
        add(0, 0, 1, 0, 32'h0,         0, 1, 32'h10, 1, 32'h0C, 32'hA000_000C);
        add(0, 0, 1, 1, 32'hA000_0010, 0, 1, 32'h14, 1, 32'h0C, 32'hA000_000C);
        add(0, 0, 1, 1, 32'hA000_0014, 0, 1, 32'h18, 1, 32'h0C, 32'hA000_000C);
        add(0, 0, 1, 1, 32'hA000_0018, 0, 0, 32'h1C, 1, 32'h0C, 32'hA000_000C);
        add(0, 0, 1, 0, 32'h0,         0, 0, 32'h1C, 1, 32'h0C, 32'hA000_000C);
        add(0, 0, 1, 0, 32'h0,         1, 0, 32'h1C, 1, 32'h0C, 32'hA000_000C);
        add(0, 0, 1, 0, 32'h0,         1, 1, 32'h1C, 1, 32'h10, 32'hA000_0010);
        add(0, 0, 1, 0, 32'h0,         0, 1, 32'h20, 1, 32'h14, 32'hA000_0014);
        // redirect with two in flight; target low bits must be ignored
        add(1, 32'h103, 1, 0, 32'h0,   0, 0, 32'h24, 1, 32'h14, 32'hA000_0014);
        add(0, 0, 0, 1, 32'hA000_001C, 0, 1, 32'h100, 0, 0, 0);
        add(0, 0, 1, 1, 32'hA000_0020, 0, 1, 32'h100, 0, 0, 0);
        add(0, 0, 1, 1, 32'hB000_0100, 1, 1, 32'h104, 0, 0, 0);
        add(0, 0, 0, 1, 32'hB000_0104, 0, 1, 32'h108, 1, 32'h100, 32'hB000_0100);
        add(0, 0, 1, 0, 32'h0,         0, 1, 32'h108, 1, 32'h100, 32'hB000_0100);
        // redirect coincident with the only outstanding response
        add(1, 32'h200, 1, 1, 32'hB000_0108, 1, 0, 32'h10C, 1, 32'h100, 32'hB000_0100);
        add(0, 0, 1, 0, 32'h0,         1, 1, 32'h200, 0, 0, 0);
        add(0, 0, 0, 1, 32'hC000_0200, 1, 1, 32'h204, 0, 0, 0);
        add(0, 0, 0, 0, 32'h0,         1, 1, 32'h204, 1, 32'h200, 32'hC000_0200);
        add(0, 0, 0, 0, 32'h0,         0, 1, 32'h204, 0, 0, 0);
        // back-to-back redirects: second wins, drop count recomputed
        add(0, 0, 1, 0, 32'h0,         0, 1, 32'h204, 0, 0, 0);
        add(1, 32'h300, 1, 0, 32'h0,   0, 0, 32'h208, 0, 0, 0);
        add(1, 32'h400, 1, 0, 32'h0,   0, 0, 32'h300, 0, 0, 0);
        add(0, 0, 1, 1, 32'hDEAD_BEEF, 0, 1, 32'h400, 0, 0, 0);
        add(0, 0, 0, 1, 32'hE000_0400, 0, 1, 32'h404, 0, 0, 0);
        add(0, 0, 0, 0, 32'h0,         1, 1, 32'h404, 1, 32'h400, 32'hE000_0400);

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst req_valid", 32'(req_valid), 32'h0);
        chk("rst instr_valid", 32'(instr_valid), 32'h0);
        chk("rst instr", instr, 32'h0);
        chk("rst pc", pc, 32'h0);
        chk("rst pc_plus4", pc_plus4, 32'h4);
        chk("rst wrap addr", w_req_addr, 32'hFFFF_FFFC);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            redirect_i    = vecs[i].redir;
            redirect_pc_i = vecs[i].rpc;
            req_ready     = vecs[i].rdy;
            rsp_valid     = vecs[i].rv;
            rsp_data      = vecs[i].rd;
            instr_ready   = vecs[i].ir;
            @(negedge clk);
            chk($sformatf("v%0d req_valid", i), 32'(req_valid), 32'(vecs[i].ereq));
            chk($sformatf("v%0d req_addr", i), req_addr, vecs[i].eaddr);
            chk($sformatf("v%0d instr_valid", i), 32'(instr_valid), 32'(vecs[i].eiv));
            if (vecs[i].eiv) begin
                chk($sformatf("v%0d pc", i), pc, vecs[i].epc);
                chk($sformatf("v%0d instr", i), instr, vecs[i].einstr);
                chk($sformatf("v%0d pc_plus4", i), pc_plus4, vecs[i].epc + 32'd4);
            end
            @(posedge clk);
            #1;
        end

        // mid-run asynchronous reset with a buffered entry and state off reset values
        redirect_i = 0; req_ready = 1; rsp_valid = 0; instr_ready = 0;
        @(posedge clk);
        #1;
        req_ready = 0; rsp_valid = 1; rsp_data = 32'h0000_0055;
        @(posedge clk);
        #1;
        rsp_valid = 0;
        chk("pre-reset instr_valid", 32'(instr_valid), 32'h1);
        chk("pre-reset pc", pc, 32'h404);
        chk("pre-reset instr", instr, 32'h55);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst req_valid", 32'(req_valid), 32'h0);
        chk("async rst instr_valid", 32'(instr_valid), 32'h0);
        chk("async rst pc", pc, 32'h0);
        chk("async rst instr", instr, 32'h0);
        chk("async rst pc_plus4", pc_plus4, 32'h4);
        chk("async rst addr", req_addr, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-reset req_valid", 32'(req_valid), 32'h1);
        chk("post-reset addr", req_addr, 32'h0);
        chk("post-reset instr_valid", 32'(instr_valid), 32'h0);

        // PC wrap from RESET_PC = 0xFFFF_FFFC
        @(posedge clk);
        #1;
        w_req_ready = 1;
        @(negedge clk);
        chk("wrap req_valid", 32'(w_req_valid), 32'h1);
        chk("wrap addr0", w_req_addr, 32'hFFFF_FFFC);
        @(posedge clk);
        #1;
        w_rsp_valid = 1; w_rsp_data = 32'h0000_0011;
        @(negedge clk);
        chk("wrap addr1", w_req_addr, 32'h0);
        @(posedge clk);
        #1;
        w_rsp_valid = 0; w_req_ready = 0;
        @(negedge clk);
        chk("wrap instr_valid", 32'(w_instr_valid), 32'h1);
        chk("wrap pc", w_pc, 32'hFFFF_FFFC);
        chk("wrap instr", w_instr, 32'h11);
        chk("wrap pc_plus4", w_pc_plus4, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_queue_stage.md
Name: fetch_queue_stage

Overview:
Parametrised IF stage for the 5-stage RV32I pipeline, replacing the single-PC/zero-latency fetch.
- Issues sequential requests to an instruction memory with a valid/ready request channel and in-order responses of variable latency.
- Buffers returned instructions in a prefetch FIFO and presents them to decode with a valid/ready handshake.
- On an EX-stage branch/jump redirect (PCSrcE), flushes the FIFO and discards in-flight responses.

Parameters:
XLEN, 32, address/instruction width
FQ_DEPTH, 4, prefetch FIFO entries; power of 2, >=2; also caps outstanding requests
RESET_PC, 32'h0000_0000, PC after reset

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
redirect_i  in  1  PCSrcE: take redirect_pc_i this cycle
redirect_pc_i  in  XLEN  PCTarget; bits [1:0] ignored (forced 0)
imem_req_valid_o  out  1  fetch request valid
imem_req_ready_i  in  1  memory accepts request
imem_req_addr_o  out  XLEN  request address (word aligned)
imem_rsp_valid_i  in  1  response valid, in request order
imem_rsp_data_i  in  XLEN  returned instruction
instr_valid_o  out  1  FIFO head valid
instr_ready_i  in  1  decode accepts (low = StallD)
instr_o  out  XLEN  head instruction
pc_o  out  XLEN  PC of head instruction
pc_plus4_o  out  XLEN  pc_o + 4, modulo 2^XLEN

Behaviour:
- Registers: fetch_pc, rsp_pc, FIFO {pc, instr} with rd/wr pointers and count (0..FQ_DEPTH), outstanding (0..FQ_DEPTH), drop_cnt (0..FQ_DEPTH).
- Reset (async): fetch_pc = rsp_pc = RESET_PC; count = outstanding = drop_cnt = 0; imem_req_valid_o = 0; instr_valid_o = 0; instr_o/pc_o = 0; pc_plus4_o = 4.
- Issue: imem_req_valid_o = !redirect_i && (count + outstanding < FQ_DEPTH), using registered values only, with no same-cycle dequeue bypass.
- imem_req_addr_o = fetch_pc.
- On req_valid && req_ready: fetch_pc += 4 (wraps at 2^XLEN) and outstanding++.
- Response: on rsp_valid, outstanding--.
  - If drop_cnt > 0: discard the response and decrement drop_cnt.
  - Otherwise: push {rsp_pc, rsp_data} and rsp_pc += 4.
  - The credit rule guarantees no overflow; a push into a full FIFO is an assertion failure.
- Output: instr_valid_o = (count != 0); head fields are driven straight from the FIFO.
  - Pop on instr_valid_o && instr_ready_i.
  - Push and pop in the same cycle leave count unchanged; a push into an empty FIFO is visible on the next cycle (1-cycle latency rsp->decode).
- Redirect (single cycle):
  - fetch_pc <= rsp_pc <= {redirect_pc_i[XLEN-1:2], 2'b00}; FIFO cleared (count=0, pointers=0).
  - drop_cnt <= outstanding minus (1 if rsp_valid_i this cycle).
  - A response arriving in the redirect cycle is discarded.
  - No request is issued in the redirect cycle.
  - A simultaneous pop is a don't-care: decode is flushed by the hazard unit the same cycle.
  - New requests may issue from the next cycle while drop_cnt > 0; in-order return guarantees stale responses arrive first.
- Back-to-back redirects: the second overrides the first; drop_cnt is recomputed from current outstanding.
- rst_n asserted mid-operation: all state returns to reset values immediately. In-flight memory responses after reset release are the memory's responsibility; the memory is reset with the same rst_n.

Optional Feature:
FETCH_PERF_CNT_EN:
- Defined: adds outputs perf_stall_cycles_o (32b), counting cycles with instr_valid_o=0 and no redirect, and perf_redirects_o (32b), counting redirect_i pulses. Both saturate at all-ones and reset to 0.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package fetch_pkg: XLEN default, NOP_INSTR = 32'h0000_0013, fetch entry typedef {pc, instr}, clog2 helper for counter widths.
- One natural sub-module: fetch_fifo, a parametrised sync FIFO with push/pop/flush, count, full/empty, and show-ahead head output. Credit/drop logic and PC stay in the top.

Test Plan:
- Reset: rst_n low, then release with RESET_PC=0 -> req addr 0x0 on the first cycle; instr_valid_o=0 until the first response.
- Streaming: zero-wait memory (ready=1, rsp 1 cycle later), decode always ready -> decode sees pc 0x0, 0x4, 0x8... one instruction per cycle after 2-cycle fill.
- Backpressure: instr_ready_i=0 for 10 cycles, FQ_DEPTH=4 -> exactly 4 requests issued, req_valid drops, no data lost. Release -> in-order drain 0x0..0xC.
- Redirect with in-flight traffic: 2 outstanding, redirect_i to 0x100 -> FIFO empty next cycle, the next 2 responses discarded, first delivered pc_o=0x100, pc_plus4_o=0x104.
- Redirect coincident with response: rsp_valid_i and redirect_i in the same cycle, outstanding=1 -> drop_cnt=0; the next response is accepted as 0x100.
- Wrap: RESET_PC=32'hFFFF_FFFC -> second request addr 0x0; pc_plus4_o=0x0 for the first instruction.
